// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: accepts PCs, issues word reads over req/ack,
// and queues {pc, instruction} pairs for decode in a small FIFO.
module inst_fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h00400020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_stall,
  input  logic        flush,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_pc_q   [DEPTH];

  logic            room_s, accept_s, push_s, pop_s;

  // A flush in the same cycle empties the FIFO, so the redirect target always has room
  assign room_s   = flush | (count_q < CW'(DEPTH));
  assign accept_s = (state_q == IDLE) & room_s & pc_valid;
  assign pc_stall = pc_valid & ~((state_q == IDLE) & room_s);
  assign push_s   = (state_q == REQ) & imem_ack & ~flush;
  assign pop_s    = (count_q != CW'(0)) & inst_ready;

  assign imem_addr  = addr_q;
  assign imem_req   = req_q;
  assign fetch_err  = err_q;
  assign inst_valid = (count_q != CW'(0));
  assign inst_out   = mem_inst_q[rd_ptr_q];
  assign inst_pc    = mem_pc_q[rd_ptr_q];

  // Fetch FSM next-state and request/address/error control
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (pc_in[1:0] == 2'b00) begin
            addr_d  = pc_in;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end else begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO occupancy; flush overrides any push or pop
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = CW'(0);
    end else if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= CW'(0);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= 32'h0;
        mem_pc_q[i]   <= 32'h0;
      end
    end else if (flush) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
    end else begin
      if (push_s) begin
        mem_inst_q[wr_ptr_q] <= imem_rdata;
        mem_pc_q[wr_ptr_q]   <= addr_q;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed self-checking bench for inst_fetch_buffer (DEPTH=2).
module tb_inst_fetch_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_stall;
  logic        flush;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;

  int checks;
  int failures;

  inst_fetch_buffer #(.DEPTH(2), .RESET_PC(32'h00400020)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_stall(pc_stall), .flush(flush), .imem_addr(imem_addr),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // full single-cycle-ack fetch starting in IDLE
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    pc_valid = 1'b1; pc_in = pc;
    step();
    pc_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; pc_in = 32'h0; pc_valid = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    step(); step();
    check_eq("rst_req",   {31'h0, imem_req},   32'h0);
    check_eq("rst_addr",  imem_addr,           32'h00400020);
    check_eq("rst_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("rst_out",   inst_out,            32'h0);
    check_eq("rst_pc",    inst_pc,             32'h0);
    check_eq("rst_err",   {31'h0, fetch_err},  32'h0);
    check_eq("rst_stall", {31'h0, pc_stall},   32'h0);
    rst_n = 1'b1;
    step();

    // basic fetch with single-cycle ack
    pc_valid = 1'b1; pc_in = 32'h00400020;
    #1 check_eq("t1_stall", {31'h0, pc_stall}, 32'h0);
    step();
    pc_valid = 1'b0;
    check_eq("t1_req",   {31'h0, imem_req},   32'h1);
    check_eq("t1_addr",  imem_addr,           32'h00400020);
    check_eq("t1_nval",  {31'h0, inst_valid}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h20080005;
    step();
    imem_ack = 1'b0;
    check_eq("t1_req0",  {31'h0, imem_req},   32'h0);
    check_eq("t1_valid", {31'h0, inst_valid}, 32'h1);
    check_eq("t1_ipc",   inst_pc,             32'h00400020);
    check_eq("t1_inst",  inst_out,            32'h20080005);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check_eq("t1_pop", {31'h0, inst_valid}, 32'h0);

    // fill FIFO, third PC stalled, then drained in order
    fetch(32'h00400020, 32'hAAAA0001);
    fetch(32'h00400024, 32'hAAAA0002);
    pc_valid = 1'b1; pc_in = 32'h00400028;
    #1 check_eq("t2_stall", {31'h0, pc_stall}, 32'h1);
    step();
    check_eq("t2_noreq", {31'h0, imem_req}, 32'h0);
    check_eq("t2_h0pc",  inst_pc,  32'h00400020);
    check_eq("t2_h0",    inst_out, 32'hAAAA0001);
    inst_ready = 1'b1;
    step();
    check_eq("t2_h1pc",   inst_pc,  32'h00400024);
    check_eq("t2_h1",     inst_out, 32'hAAAA0002);
    check_eq("t2_unstall", {31'h0, pc_stall}, 32'h0);
    step();
    pc_valid = 1'b0; inst_ready = 1'b0;
    check_eq("t2_empty", {31'h0, inst_valid}, 32'h0);
    check_eq("t2_req3",  {31'h0, imem_req},   32'h1);
    check_eq("t2_addr3", imem_addr,           32'h00400028);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA0003;
    step();
    imem_ack = 1'b0;
    check_eq("t2_h2pc", inst_pc,  32'h00400028);
    check_eq("t2_h2",   inst_out, 32'hAAAA0003);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // ack delayed 5 cycles
    pc_valid = 1'b1; pc_in = 32'h00400030;
    step();
    pc_in = 32'h00400034;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_req",   {31'h0, imem_req}, 32'h1);
      check_eq("t3_addr",  imem_addr,         32'h00400030);
      check_eq("t3_stall", {31'h0, pc_stall}, 32'h1);
      step();
    end
    pc_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBBBB0001;
    step();
    imem_ack = 1'b0;
    check_eq("t3_pc",   inst_pc,  32'h00400030);
    check_eq("t3_inst", inst_out, 32'hBBBB0001);

    // flush in REQ with one entry buffered
    pc_valid = 1'b1; pc_in = 32'h00400040;
    step();
    pc_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t4_nval",  {31'h0, inst_valid}, 32'h0);
    check_eq("t4_drain", {31'h0, imem_req},   32'h1);
    step(); step();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    check_eq("t4_noent", {31'h0, inst_valid}, 32'h0);
    check_eq("t4_req0",  {31'h0, imem_req},   32'h0);
    fetch(32'h00400100, 32'hCCCC0001);
    check_eq("t4_pc",   inst_pc,  32'h00400100);
    check_eq("t4_inst", inst_out, 32'hCCCC0001);
    fetch(32'h00400104, 32'hCCCC0002);

    // flush plus redirect PC in IDLE with full FIFO
    flush = 1'b1; pc_valid = 1'b1; pc_in = 32'h00400200;
    step();
    flush = 1'b0; pc_valid = 1'b0;
    check_eq("t5_nval", {31'h0, inst_valid}, 32'h0);
    check_eq("t5_req",  {31'h0, imem_req},   32'h1);
    check_eq("t5_addr", imem_addr,           32'h00400200);
    imem_ack = 1'b1; imem_rdata = 32'hEEEE0001;
    step();
    imem_ack = 1'b0;
    check_eq("t5_pc",   inst_pc,  32'h00400200);
    check_eq("t5_inst", inst_out, 32'hEEEE0001);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // flush coinciding with ack in REQ: data discarded, back to IDLE
    pc_valid = 1'b1; pc_in = 32'h00400300;
    step();
    pc_valid = 1'b0;
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h12345678;
    step();
    flush = 1'b0; imem_ack = 1'b0;
    check_eq("t6_req0", {31'h0, imem_req},   32'h0);
    check_eq("t6_nval", {31'h0, inst_valid}, 32'h0);
    pc_valid = 1'b1; pc_in = 32'h00400304;
    #1 check_eq("t6_idle", {31'h0, pc_stall}, 32'h0);
    pc_valid = 1'b0;

    // misaligned PC sets sticky error; reset clears it asynchronously
    pc_valid = 1'b1; pc_in = 32'h00400022;
    step();
    pc_valid = 1'b0;
    check_eq("t7_noreq", {31'h0, imem_req},   32'h0);
    check_eq("t7_err",   {31'h0, fetch_err},  32'h1);
    check_eq("t7_nval",  {31'h0, inst_valid}, 32'h0);
    pc_valid = 1'b1; pc_in = 32'h00400400;
    step();
    pc_valid = 1'b0;
    check_eq("t7_sticky", {31'h0, fetch_err}, 32'h1);
    check_eq("t7_req",    {31'h0, imem_req},  32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t7_errclr", {31'h0, fetch_err}, 32'h0);
    check_eq("t7_reqclr", {31'h0, imem_req},  32'h0);
    check_eq("t7_addrrst", imem_addr,         32'h00400020);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h55555555;
    step();
    imem_ack = 1'b0;
    check_eq("t7_lateack", {31'h0, inst_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
